// File: rtl/ifetch_queue.sv
// Instruction fetch unit: drives a 1-cycle synchronous ROM and buffers fetched
// words in a DEPTH-entry prefetch FIFO with a valid/ready decode interface.
`timescale 1ns/1ps
module ifetch_queue #(
  parameter int              PC_W     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [PC_W-3:0] mem_addr,
  input  logic [31:0]     mem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t [DEPTH-1:0] fifo_q, fifo_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic               kill_q, kill_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW:0]        occupancy;
  logic               issue, push, pop;

  // Credit counts the in-flight word so a response always has a free slot.
  assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue      = rst && !redirect && (occupancy < DEPTH_V);
  assign push       = inflight_q && !kill_q && !redirect;
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;

  assign mem_req  = issue;
  assign mem_addr = fetch_pc_q[PC_W-1:2];
  assign inst     = inst_valid ? fifo_q[rd_ptr_q].inst : 32'h0;
  assign inst_pc  = inst_valid ? fifo_q[rd_ptr_q].pc : '0;

  always_comb begin
    fifo_d        = fifo_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    kill_d        = redirect && issue;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (issue) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_W'(4);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = '{pc: inflight_pc_q, inst: mem_rdata};
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Flush after any same-cycle handshake; the pending response was already dropped via push.
    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q        <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fifo_q        <= fifo_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end
endmodule
